// File: rtl/regfile_wport_arbiter_pkg.sv
// rtl/regfile_wport_arbiter_pkg.sv - shared CPU constants and write-port arbiter state type
package regfile_wport_arbiter_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_A0   = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// rtl/regfile_wport_arbiter_if.sv - writeback, side-request and register-file write bus
interface regfile_wport_arbiter_if #(
    parameter int XLEN = regfile_wport_arbiter_pkg::XLEN
);
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            ecall_valid;
    logic [XLEN-1:0] ecall_data;
    logic            ecall_ready;

    logic            dbg_valid;
    logic [4:0]      dbg_rd;
    logic [XLEN-1:0] dbg_data;
    logic            dbg_ready;

    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    logic            pipe_hold;
    logic [31:0]     pend_mask;
    logic            proto_err;

    modport master (
        output wb_we, wb_rd, wb_data,
        output ecall_valid, ecall_data,
        output dbg_valid, dbg_rd, dbg_data,
        input  ecall_ready, dbg_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  pipe_hold, pend_mask, proto_err
    );

    modport slave (
        input  wb_we, wb_rd, wb_data,
        input  ecall_valid, ecall_data,
        input  dbg_valid, dbg_rd, dbg_data,
        output ecall_ready, dbg_ready,
        output rf_we, rf_waddr, rf_wdata,
        output pipe_hold, pend_mask, proto_err
    );

endinterface

// File: rtl/regfile_wport_arbiter_wport_buf.sv
// rtl/regfile_wport_arbiter_wport_buf.sv - one-entry valid/ready holding register for a side write
module wport_buf #(
    parameter int XLEN = regfile_wport_arbiter_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] data_i,
    output logic            ready_o,
    input  logic            drain_i,
    output logic            fill_o,
    output logic            full_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] data_o
);
    import regfile_wport_arbiter_pkg::*;

    logic            full_q, full_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;

    assign ready_o = rst & ~full_q;
    // writes to x0 complete the handshake but are dropped here
    assign fill_o  = valid_i & ready_o & (rd_i != REG_ZERO);

    always_comb begin
        full_d = full_q;
        rd_d   = rd_q;
        data_d = data_q;
        if (fill_o) begin
            full_d = 1'b1;
            rd_d   = rd_i;
            data_d = data_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= 1'b0;
            rd_q   <= REG_ZERO;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign rd_o   = rd_q;
    assign data_o = data_q;

endmodule

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - register-file write-port arbiter: writeback first, buffered side writes drained into idle cycles
module regfile_wport_arbiter #(
    parameter int XLEN         = regfile_wport_arbiter_pkg::XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_wport_arbiter_if.slave  bus
);
    import regfile_wport_arbiter_pkg::*;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_PEND = PEND;
    localparam logic [1:0] S_HOLD = HOLD;
    localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

    logic            e_full, e_fill, e_drain;
    logic            d_full, d_fill, d_drain;
    logic [4:0]      e_rd, d_rd;
    logic [XLEN-1:0] e_data, d_data;
    logic            wb_sel, any_drain, any_full_d;

    logic [1:0]      state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic            pipe_hold_q;
    logic            proto_err_q, proto_err_d;

    // writeback to x0 leaves the port free for a buffered write
    assign wb_sel    = bus.wb_we & (bus.wb_rd != REG_ZERO);
    assign e_drain   = rst & ~wb_sel & e_full;
    assign d_drain   = rst & ~wb_sel & ~e_full & d_full;
    assign any_drain = e_drain | d_drain;

    wport_buf #(.XLEN(XLEN)) u_ecall_buf (
        .clk     (clk),
        .rst     (rst),
        .valid_i (bus.ecall_valid),
        .rd_i    (REG_A0),
        .data_i  (bus.ecall_data),
        .ready_o (bus.ecall_ready),
        .drain_i (e_drain),
        .fill_o  (e_fill),
        .full_o  (e_full),
        .rd_o    (e_rd),
        .data_o  (e_data)
    );

    wport_buf #(.XLEN(XLEN)) u_dbg_buf (
        .clk     (clk),
        .rst     (rst),
        .valid_i (bus.dbg_valid),
        .rd_i    (bus.dbg_rd),
        .data_i  (bus.dbg_data),
        .ready_o (bus.dbg_ready),
        .drain_i (d_drain),
        .fill_o  (d_fill),
        .full_o  (d_full),
        .rd_o    (d_rd),
        .data_o  (d_data)
    );

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = REG_ZERO;
        bus.rf_wdata = '0;
        if (rst && wb_sel) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.wb_rd;
            bus.rf_wdata = bus.wb_data;
        end else if (e_drain) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = e_rd;
            bus.rf_wdata = e_data;
        end else if (d_drain) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = d_rd;
            bus.rf_wdata = d_data;
        end
    end

    assign any_full_d = e_fill | (e_full & ~e_drain) | d_fill | (d_full & ~d_drain);

    always_comb begin
        state_d  = state_q;
        starve_d = '0;
        case (state_q)
            S_IDLE: begin
                if (any_full_d) state_d = S_PEND;
            end
            S_PEND: begin
                if (!any_full_d) begin
                    state_d = S_IDLE;
                end else if (!any_drain) begin
                    if (starve_q == LIMIT) state_d = S_HOLD;
                    else                   starve_d = starve_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (!any_full_d) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign proto_err_d = proto_err_q | ((state_q == S_HOLD) & bus.wb_we);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            pipe_hold_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            pipe_hold_q <= (state_d == S_HOLD);
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        bus.pend_mask = '0;
        if (d_full) bus.pend_mask[d_rd] = 1'b1;
        if (e_full) bus.pend_mask[e_rd] = 1'b1;
        bus.pend_mask[REG_ZERO] = 1'b0;
    end

    assign bus.pipe_hold = pipe_hold_q;
    assign bus.proto_err = proto_err_q;

endmodule
